// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder slice plus a carry flop, LSB first.
// Result, Cout and Ovf only change on completion or reset.
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic             Cout,
    output logic             Ovf
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] op_a, op_b, acc;
    logic             carry;
    logic [CW-1:0]    count;
    logic             sum_bit, carry_next, last_bit;

    assign sum_bit    = op_a[0] ^ op_b[0] ^ carry;
    assign carry_next = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
    assign last_bit   = (count == LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // On the last bit the current carry is the carry into the MSB, so overflow
    // is that carry XOR the carry leaving the MSB.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op_a   <= '0;
            op_b   <= '0;
            acc    <= '0;
            carry  <= 1'b0;
            count  <= '0;
            Result <= '0;
            Cout   <= 1'b0;
            Ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a  <= A;
                        op_b  <= op ? ~B : B;
                        carry <= op;
                        count <= '0;
                    end
                end
                RUN: begin
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    acc   <= {sum_bit, acc[WIDTH-1:1]};
                    carry <= carry_next;
                    count <= count + 1'b1;
                    if (last_bit) begin
                        Result <= {sum_bit, acc[WIDTH-1:1]};
                        Cout   <= carry_next;
                        Ovf    <= carry ^ carry_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule
